// File: rtl/snn_pkg.sv
// Shared SNN definitions: neuron FSM states, default widths, saturating add.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
package snn_pkg;

  localparam int N_IN_DEF       = 16;
  localparam int W_W_DEF        = 8;
  localparam int V_W_DEF        = 16;
  localparam int LEAK_SHIFT_DEF = 4;
  localparam int REFRAC_DEF     = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    LEAK  = 2'd2,
    FIRE  = 2'd3
  } snn_state_e;

  // Saturating add of a default-width weight onto a default-width potential.
  // The sum is formed one bit wider so the overflow can be seen and clamped.
  function automatic logic signed [V_W_DEF-1:0] sat_add(
    input logic signed [V_W_DEF-1:0] a,
    input logic signed [W_W_DEF-1:0] b
  );
    logic [V_W_DEF:0] s;
    s = {a[V_W_DEF-1], a} + {{(V_W_DEF+1-W_W_DEF){b[W_W_DEF-1]}}, b};
    if (s[V_W_DEF] != s[V_W_DEF-1]) begin
      sat_add = s[V_W_DEF] ? {1'b1, {(V_W_DEF-1){1'b0}}} : {1'b0, {(V_W_DEF-1){1'b1}}};
    end else begin
      sat_add = s[V_W_DEF-1:0];
    end
  endfunction

endpackage

// File: rtl/snn_sat_add.sv
// Signed saturating adder: sign-extends a W_W weight onto a V_W potential and clamps.
// Latency: combinational, zero cycles.
// Backpressure: none.
module snn_sat_add #(
  parameter int V_W = 16,
  parameter int W_W = 8
) (
  input  logic signed [V_W-1:0] i_a,
  input  logic signed [W_W-1:0] i_b,
  output logic signed [V_W-1:0] o_sum
);

  logic [V_W:0] w_sum;

  // One extra bit of headroom: the top two bits disagree exactly on overflow
  assign w_sum = {i_a[V_W-1], i_a} + {{(V_W+1-W_W){i_b[W_W-1]}}, i_b};

  // Clamp toward the overflowed side, otherwise pass the true sum
  always_comb begin
    o_sum = w_sum[V_W-1:0];
    if (w_sum[V_W] != w_sum[V_W-1]) begin
      o_sum = w_sum[V_W] ? {1'b1, {(V_W-1){1'b0}}} : {1'b0, {(V_W-1){1'b1}}};
    end
  end

endmodule

// File: rtl/snn_lif_neuron.sv
// LIF neuron: serial N_IN-synapse accumulate (saturating), shift leak, threshold fire, refractory; SNN_NEG_CLAMP_EN clamps v_mem >= 0.
// Latency: start sampled at cycle T -> done/spike_out pulse at T+N_IN+2; back-to-back one timestep per N_IN+3 cycles.
// Backpressure: none; start is ignored (not queued) while busy, inputs are latched on the start cycle.
module snn_lif_neuron
  import snn_pkg::*;
#(
  parameter int N_IN       = N_IN_DEF,
  parameter int W_W        = W_W_DEF,
  parameter int V_W        = V_W_DEF,
  parameter int LEAK_SHIFT = LEAK_SHIFT_DEF,
  parameter int REFRAC     = REFRAC_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  input  logic [N_IN-1:0]       i_spike_vec,
  input  logic [N_IN*W_W-1:0]   i_weights,
  input  logic signed [V_W-1:0] i_threshold,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_spike_out,
  output logic signed [V_W-1:0] o_v_mem
);

  localparam int IDX_W = $clog2(N_IN);
  localparam int RC_W  = (REFRAC < 1) ? 1 : $clog2(REFRAC + 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_IN - 1);
  localparam logic [RC_W-1:0]  RC_INIT  = RC_W'(REFRAC);

  snn_state_e r_state;
  snn_state_e w_state_nxt;

  logic [N_IN-1:0]       r_spk;
  logic [N_IN*W_W-1:0]   r_wts;
  logic signed [V_W-1:0] r_thr;
  logic [IDX_W-1:0]      r_idx;
  logic signed [V_W-1:0] r_v;
  logic [RC_W-1:0]       r_rc;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_spike;

  logic signed [W_W-1:0] w_wsel;
  logic signed [V_W-1:0] w_acc_sum;
  logic signed [V_W-1:0] w_acc_v;
  logic signed [V_W-1:0] w_leak;
  logic signed [V_W-1:0] w_leak_v;
  logic                  w_acc_en;
  logic                  w_fire;

  assign w_wsel   = r_wts[r_idx*W_W +: W_W];
  // A refractory neuron ignores its inputs for the whole timestep
  assign w_acc_en = r_spk[r_idx] && (r_rc == '0);

  snn_sat_add #(
    .V_W (V_W),
    .W_W (W_W)
  ) u_sat_add (
    .i_a   (r_v),
    .i_b   (w_wsel),
    .o_sum (w_acc_sum)
  );

  // v - (v >>> s) shrinks |v| toward zero and can never overflow
  assign w_leak = r_v - (r_v >>> LEAK_SHIFT);

`ifdef SNN_NEG_CLAMP_EN
  assign w_acc_v  = w_acc_sum[V_W-1] ? '0 : w_acc_sum;
  assign w_leak_v = w_leak[V_W-1]    ? '0 : w_leak;
`else
  assign w_acc_v  = w_acc_sum;
  assign w_leak_v = w_leak;
`endif

  assign w_fire = (r_rc == '0) && (r_v >= r_thr);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state: fixed walk IDLE -> ACCUM x N_IN -> LEAK -> FIRE -> IDLE
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (i_start) w_state_nxt = ACCUM;
      ACCUM:   if (r_idx == IDX_LAST) w_state_nxt = LEAK;
      LEAK:    w_state_nxt = FIRE;
      FIRE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Datapath: input latch, synapse walk, leak, fire decision and refractory count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_spk   <= '0;
      r_wts   <= '0;
      r_thr   <= '0;
      r_idx   <= '0;
      r_v     <= '0;
      r_rc    <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_spike <= 1'b0;
    end else begin
      r_done  <= 1'b0;
      r_spike <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_spk  <= i_spike_vec;
            r_wts  <= i_weights;
            r_thr  <= i_threshold;
            r_idx  <= '0;
            r_busy <= 1'b1;
          end
        end
        ACCUM: begin
          if (w_acc_en) r_v <= w_acc_v;
          r_idx <= r_idx + 1'b1;
        end
        LEAK: begin
          r_v <= w_leak_v;
        end
        FIRE: begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
          if (w_fire) begin
            r_spike <= 1'b1;
            r_v     <= '0;
            r_rc    <= RC_INIT;
          end else if (r_rc != '0) begin
            r_rc <= r_rc - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_spike_out = r_spike;
  assign o_v_mem     = r_v;

endmodule
